// File: rtl/switch_debounce_sync_if.sv
// switch_debounce_sync_if: switch-side bundle between raw pins and the PIO/control side
//   sw_raw     raw switch pins (driven by master)
//   change_clr sticky-flag clear (driven by master)
//   sw_db      debounced level (driven by slave)
//   sw_rise    accepted 0->1 pulses (driven by slave)
//   sw_fall    accepted 1->0 pulses (driven by slave)
//   change     sticky "some bit changed" flag (driven by slave)
interface switch_debounce_sync_if #(parameter int WIDTH = 18);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             change;
  logic             change_clr;
  modport master (output sw_raw, change_clr, input sw_db, sw_rise, sw_fall, change);
  modport slave  (input sw_raw, change_clr, output sw_db, sw_rise, sw_fall, change);
endinterface

// File: rtl/switch_debounce_sync.sv
// switch_debounce_sync: 2-flop sync + tick-sampled debounce of WIDTH switches with edge pulses
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      slave side of switch_debounce_sync_if (sw_raw/change_clr in; sw_db/sw_rise/sw_fall/change out)
module switch_debounce_sync #(
  parameter int WIDTH        = 18,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8
) (
  input logic                   clk,
  input logic                   reset_n,
  switch_debounce_sync_if.slave bus
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  logic [WIDTH-1:0] sync1, sync2, db, rise, fall, acc;
  logic [PW-1:0]    pcnt;
  logic             tick, chg;
  logic [CW-1:0]    cnt [WIDTH];
  assign tick = pcnt == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      pcnt  <= '0;
      db    <= '0;
      rise  <= '0;
      fall  <= '0;
      chg   <= 1'b0;
    end else begin
      sync1 <= bus.sw_raw;
      sync2 <= sync1;
      pcnt  <= tick ? '0 : pcnt + PW'(1);
      db    <= db ^ acc;
      rise  <= acc & sync2;
      fall  <= acc & ~sync2;
      chg   <= (|(rise | fall)) | (chg & ~bus.change_clr);
    end
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    // accept on the STABLE_TICKS-th tick of an unbroken mismatch run
    assign acc[g] = (sync2[g] != db[g]) && tick && cnt[g] == CW'(STABLE_TICKS - 1);
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt[g] <= '0;
      else cnt[g] <= (sync2[g] == db[g] || acc[g]) ? '0 : tick ? cnt[g] + CW'(1) : cnt[g];
  end
  assign bus.sw_db   = db;
  assign bus.sw_rise = rise;
  assign bus.sw_fall = fall;
  // the flag shows in the pulse cycle itself; the register keeps it so a clear in that cycle loses
  assign bus.change  = chg | (|(rise | fall));
endmodule

// File: tb/tb_switch_debounce_sync.sv
// tb_switch_debounce_sync: table, corner-sequence and random checks against a tick-counting reference
module tb_switch_debounce_sync;
  localparam int W = 18, TD = 4, ST = 3;
  typedef struct {
    int b;
    int hold;
    int rises;
    int falls;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0, n_fail = 0;
  switch_debounce_sync_if #(.WIDTH(W)) bus ();
  switch_debounce_sync #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk = ~clk;
  int         m_n;
  logic [W-1:0] m_hist [$];
  logic [W-1:0] m_db, m_rise, m_fall;
  logic       m_chg;
  int         m_start [W];
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_n = 0;
    m_hist.delete();
    m_db = '0;
    m_rise = '0;
    m_fall = '0;
    m_chg = 1'b0;
    for (int i = 0; i < W; i++) m_start[i] = -1;
  endtask
  // edge n after release; sync seen at edge n is the raw value present at edge n-2;
  // a tick edge is every TD-th edge; a bit flips on the ST-th tick edge of a continuous mismatch run
  task automatic model_edge(input logic [W-1:0] raw, input logic clr);
    logic [W-1:0] s;
    logic nchg;
    m_n++;
    s = m_hist.size() >= 2 ? m_hist[m_hist.size()-2] : '0;
    m_hist.push_back(raw);
    if (m_hist.size() > 3) void'(m_hist.pop_front());
    nchg = (|(m_rise | m_fall)) | (m_chg & ~clr);
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      if (s[i] == m_db[i]) m_start[i] = -1;
      else begin
        if (m_start[i] < 0) m_start[i] = m_n;
        if (m_n % TD == 0 && (m_n / TD - (m_start[i] - 1) / TD) >= ST) begin
          m_db[i] = s[i];
          m_rise[i] = s[i];
          m_fall[i] = ~s[i];
          m_start[i] = -1;
        end
      end
    end
    m_chg = nchg;
  endtask
  task automatic step(input logic [W-1:0] raw, input logic clr);
    bus.sw_raw = raw;
    bus.change_clr = clr;
    @(posedge clk);
    model_edge(raw, clr);
    @(negedge clk);
    chk("sw_db", bus.sw_db, m_db);
    chk("sw_rise", bus.sw_rise, m_rise);
    chk("sw_fall", bus.sw_fall, m_fall);
    chk("change", W'(bus.change), W'(m_chg | (|(m_rise | m_fall))));
  endtask
  task automatic do_reset(input logic [W-1:0] raw);
    bus.sw_raw = raw;
    bus.change_clr = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_db", bus.sw_db, '0);
    chk("rst_rise", bus.sw_rise, '0);
    chk("rst_fall", bus.sw_fall, '0);
    chk("rst_change", W'(bus.change), '0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  initial begin
    vec_t tbl [7];
    logic [W-1:0] raw;
    int k, nr, nf;
    tbl[0] = '{5, 6, 0, 0};
    tbl[1] = '{1, 8, 0, 0};
    tbl[2] = '{4, 9, 0, 0};
    tbl[3] = '{6, 10, 1, 1};
    tbl[4] = '{2, 12, 1, 1};
    tbl[5] = '{9, 2, 0, 0};
    tbl[6] = '{17, 30, 1, 1};
    bus.sw_raw = '0;
    bus.change_clr = 1'b0;
    #2;
    do_reset('0);
    // pulse-length table: hold bit high for 'hold' cycles from reset, then low for 40
    foreach (tbl[j]) begin
      do_reset('0);
      raw = '0;
      raw[tbl[j].b] = 1'b1;
      nr = 0;
      nf = 0;
      for (int c = 0; c < tbl[j].hold + 40; c++) begin
        step(c < tbl[j].hold ? raw : '0, 1'b0);
        nr += int'(bus.sw_rise[tbl[j].b]);
        nf += int'(bus.sw_fall[tbl[j].b]);
      end
      chk("tbl_rises", W'(nr), W'(tbl[j].rises));
      chk("tbl_falls", W'(nf), W'(tbl[j].falls));
      chk("tbl_final_db", bus.sw_db, '0);
    end
    // single-bit latency
    do_reset('0);
    k = 0;
    nr = 0;
    for (int c = 1; c <= 20 && k == 0; c++) begin
      step(W'(1), 1'b0);
      if (bus.sw_db[0]) k = c;
    end
    chk("lat_bit0_in_window", W'(k >= 11 && k <= 14), W'(1));
    chk("lat_rise0", bus.sw_rise, W'(1));
    chk("lat_change", W'(bus.change), W'(1));
    step(W'(1), 1'b0);
    chk("lat_rise_once", bus.sw_rise, '0);
    // all bits at once
    do_reset('0);
    k = 0;
    for (int c = 1; c <= 20 && k == 0; c++) begin
      step('1, 1'b0);
      if (bus.sw_db != '0) k = c;
    end
    chk("all_db", bus.sw_db, '1);
    chk("all_rise", bus.sw_rise, '1);
    step('1, 1'b1);
    chk("all_change_held_by_set", W'(bus.change), W'(1));
    step('1, 1'b1);
    chk("all_change_cleared", W'(bus.change), '0);
    // clear colliding with a new fall pulse
    raw = '1;
    raw[2] = 1'b0;
    k = 0;
    for (int c = 1; c <= 20 && k == 0; c++) begin
      step(raw, 1'b0);
      if (bus.sw_fall[2]) k = c;
    end
    chk("fall2_seen", W'(k != 0), W'(1));
    step(raw, 1'b1);
    chk("clr_vs_set", W'(bus.change), W'(1));
    step(raw, 1'b1);
    chk("clr_alone", W'(bus.change), '0);
    // reset in the middle of a count
    do_reset(W'(1) << 7);
    for (int c = 0; c < 9; c++) step(W'(1) << 7, 1'b0);
    do_reset(W'(1) << 7);
    k = 0;
    nr = 0;
    for (int c = 1; c <= 20; c++) begin
      step(W'(1) << 7, 1'b0);
      if (bus.sw_db[7] && k == 0) k = c;
      nr += int'(bus.sw_rise[7]);
    end
    chk("rst_mid_lat", W'(k >= 11 && k <= 14), W'(1));
    chk("rst_mid_rises", W'(nr), W'(1));
    // chatter faster than the debounce window
    do_reset('0);
    nr = 0;
    for (int c = 0; c < 200; c++) begin
      step(W'((c / 3) % 2) << 3, 1'b0);
      nr += int'(bus.sw_db[3]);
    end
    chk("chatter_db3_never", W'(nr), '0);
    // random slow-changing switches with random clears
    do_reset('0);
    raw = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < W; i++) if ($urandom_range(0, 24) == 0) raw[i] = ~raw[i];
      step(raw, $urandom_range(0, 7) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/switch_debounce_sync.md
SWITCH_DEBOUNCE_SYNC -- requirements
Module: switch_debounce_sync

Interface
REQ-001 SHALL provide parameter WIDTH, default 18, number of switch inputs (the PIO in_port width).
REQ-002 SHALL provide parameter TICK_DIV, default 50000, clk cycles per debounce sample tick (1 ms at 50 MHz); legal range >= 1.
REQ-003 SHALL provide parameter STABLE_TICKS, default 8, consecutive mismatching ticks required to accept a new level; legal range >= 1.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sw_raw  input  WIDTH  raw switch pins, asynchronous to clk.
REQ-007 SHALL have port sw_db  output  WIDTH  debounced level, drives PIO in_port.
REQ-008 SHALL have port sw_rise  output  WIDTH  one-cycle pulse per bit on accepted 0->1.
REQ-009 SHALL have port sw_fall  output  WIDTH  one-cycle pulse per bit on accepted 1->0.
REQ-010 SHALL have port change  output  1  sticky flag: at least one sw_db bit changed since last clear.
REQ-011 SHALL have port change_clr  input  1  synchronous clear of change, level-sampled each cycle.

Function
REQ-012 Each sw_raw bit SHALL pass through a 2-flop synchronizer; the second-stage output (sync) is the only value used downstream.
REQ-013 A shared prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be high for the single cycle in which count == TICK_DIV-1; TICK_DIV=1 gives tick every cycle.
REQ-014 Each bit SHALL own a stability counter of width clog2(STABLE_TICKS+1), saturation never reached.
REQ-015 When sync[i] == sw_db[i], counter[i] SHALL clear to 0 on that clock, regardless of tick.
REQ-016 When sync[i] != sw_db[i] and tick, counter[i] SHALL increment, unless counter[i] == STABLE_TICKS-1.
REQ-017 When sync[i] != sw_db[i], tick and counter[i] == STABLE_TICKS-1: sw_db[i] SHALL take sync[i] and counter[i] SHALL clear on the same edge.
REQ-018 A mismatch lasting fewer than STABLE_TICKS ticks SHALL leave sw_db[i] unchanged and produce no pulse.
REQ-019 sw_rise[i]/sw_fall[i] SHALL be registered and high exactly in the first cycle sw_db[i] shows the new value; never both high for one bit.
REQ-020 Bits SHALL be independent; any number of bits may update and pulse in the same cycle.
REQ-021 change SHALL set in the cycle any sw_rise or sw_fall bit is high and hold until change_clr; set and clear in the same cycle -> change = 1 (set wins).
REQ-022 Latency raw->sw_db SHALL be 2 sync cycles + tick-alignment + (STABLE_TICKS-1)*TICK_DIV + 1 cycles; minimum 2+(STABLE_TICKS-1)*TICK_DIV+1, maximum minimum+TICK_DIV-1.
REQ-023 Prescaler SHALL free-run; it is not restarted by input activity.

Reset
REQ-024 On reset_n low, synchronizer flops, prescaler, all counters, sw_db, sw_rise, sw_fall and change SHALL go to 0 immediately.
REQ-025 Reset asserted mid-count SHALL discard partial counts; after release a bit held at 1 SHALL be re-debounced from zero and produce a sw_rise pulse on acceptance.
REQ-026 After reset release, first tick SHALL occur TICK_DIV cycles after the first active edge.

Verification (TICK_DIV=4, STABLE_TICKS=3, WIDTH=18)
REQ-027 sw_raw[0] 0->1 held -> sw_db[0]=1 between 11 and 14 clocks after the sampling edge, sw_rise[0] high exactly 1 cycle, change=1, all other outputs 0.
REQ-028 sw_raw[5] pulsed high 6 cycles then low -> sw_db, sw_rise, sw_fall, change stay 0 throughout.
REQ-029 sw_raw = 18'h3FFFF in one cycle from 0 -> all sw_db bits and all sw_rise bits assert in the same cycle; change sets once.
REQ-030 change=1, then change_clr asserted in the same cycle as a new sw_fall[2] -> change remains 1; change_clr alone next cycle -> change = 0.
REQ-031 sw_raw[7] held high, reset_n pulsed low 1 cycle after 2 ticks of counting -> all outputs 0 during reset; sw_db[7] rises 11-14 cycles after release with one sw_rise[7] pulse.
REQ-032 sw_raw[3] toggled every 3 cycles for 200 cycles -> sw_db[3] never changes.
